lsu_arbiter: RTL and testbench

Shares the single LSU port between two requesters: the pipeline MEM stage (core) and the debug/bootloader master (dbg). Core has fixed priority. A starvation counter forces a dbg grant after a bounded wait, and a lock lets dbg run uninterrupted bursts, for example filling data memory or driving LCD/HEX. Load data is captured into a per-requester response register.

---
 rtl/lsu_arb_pkg.sv | 16 +
 rtl/lsu_arb_rsp.sv | 28 ++
 rtl/lsu_arbiter.sv | 135 +++++++++++++
 tb/tb_lsu_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_arb_pkg.sv
// Shared types for the LSU port arbiter: arbitration states and load size codes.
package lsu_arb_pkg;

  typedef enum logic [1:0] {
    S_CORE_PRI  = 2'd0,
    S_DBG_FORCE = 2'd1,
    S_LOCK      = 2'd2
  } arb_state_e;

  localparam logic [3:0] LT_BYTE = 4'h1;
  localparam logic [3:0] LT_HALF = 4'h3;
  localparam logic [3:0] LT_WORD = 4'hF;

  localparam int unsigned STARVE_W = 8;

endpackage

// File: rtl/lsu_arb_rsp.sv
// Per-requester load response: captures LSU read data on a granted load and
// pulses rsp_valid for one cycle afterwards.
module lsu_arb_rsp (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_capture,
  input  logic [31:0] i_ld_data,
  output logic        o_rsp_valid,
  output logic [31:0] o_ld_data
);

  logic        valid_q;
  logic [31:0] data_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= i_capture;
      if (i_capture) data_q <= i_ld_data;
    end
  end

  assign o_rsp_valid = valid_q;
  assign o_ld_data   = data_q;

endmodule

// File: rtl/lsu_arbiter.sv
// Two-requester arbiter for the shared LSU port: core has fixed priority, dbg
// gets a forced grant after STARVE_MAX waiting cycles and may lock the bus.
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_core_req,
  input  logic        i_core_wren,
  input  logic [31:0] i_core_addr,
  input  logic [31:0] i_core_st_data,
  input  logic [3:0]  i_core_load_type,
  input  logic        i_core_load_signed,
  input  logic        i_dbg_req,
  input  logic        i_dbg_wren,
  input  logic [31:0] i_dbg_addr,
  input  logic [31:0] i_dbg_st_data,
  input  logic [3:0]  i_dbg_load_type,
  input  logic        i_dbg_load_signed,
  input  logic        i_dbg_lock,
  output logic        o_core_gnt,
  output logic        o_dbg_gnt,
  output logic        o_core_rsp_valid,
  output logic        o_dbg_rsp_valid,
  output logic [31:0] o_core_ld_data,
  output logic [31:0] o_dbg_ld_data,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_lsu_st_data,
  output logic        o_lsu_wren,
  output logic [3:0]  o_lsu_load_type,
  output logic        o_lsu_load_signed,
  input  logic [31:0] i_lsu_ld_data,
  output logic        o_dbg_locked
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                core_gnt, dbg_gnt;

  // Grants are masked by reset so a store in flight is cut off immediately.
  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    if (i_reset) begin
      case (state_q)
        S_DBG_FORCE: begin
          dbg_gnt  = i_dbg_req;
          core_gnt = i_core_req & ~i_dbg_req;
        end
        S_LOCK: begin
          dbg_gnt  = i_dbg_req;
          core_gnt = 1'b0;
        end
        default: begin
          core_gnt = i_core_req;
          dbg_gnt  = i_dbg_req & ~i_core_req;
        end
      endcase
    end
  end

  always_comb begin
    o_lsu_addr        = '0;
    o_lsu_st_data     = '0;
    o_lsu_wren        = 1'b0;
    o_lsu_load_type   = '0;
    o_lsu_load_signed = 1'b0;
    if (core_gnt) begin
      o_lsu_addr        = i_core_addr;
      o_lsu_st_data     = i_core_st_data;
      o_lsu_wren        = i_core_wren;
      o_lsu_load_type   = i_core_load_type;
      o_lsu_load_signed = i_core_load_signed;
    end else if (dbg_gnt) begin
      o_lsu_addr        = i_dbg_addr;
      o_lsu_st_data     = i_dbg_st_data;
      o_lsu_wren        = i_dbg_wren;
      o_lsu_load_type   = i_dbg_load_type;
      o_lsu_load_signed = i_dbg_load_signed;
    end
  end

  always_comb begin
    starve_d = starve_q;
    state_d  = state_q;
    if (dbg_gnt || !i_dbg_req) starve_d = '0;
    else if (starve_q < STARVE_LIM) starve_d = starve_q + 1'b1;

    case (state_q)
      S_CORE_PRI:  if (starve_d == STARVE_LIM) state_d = S_DBG_FORCE;
      S_DBG_FORCE: if (dbg_gnt || !i_dbg_req) state_d = S_CORE_PRI;
      S_LOCK:      if (!i_dbg_lock) state_d = S_CORE_PRI;
      default:     state_d = S_CORE_PRI;
    endcase

    if (dbg_gnt && i_dbg_lock) state_d = S_LOCK;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= S_CORE_PRI;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  lsu_arb_rsp u_core_rsp (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_capture   (core_gnt & ~i_core_wren),
    .i_ld_data   (i_lsu_ld_data),
    .o_rsp_valid (o_core_rsp_valid),
    .o_ld_data   (o_core_ld_data)
  );

  lsu_arb_rsp u_dbg_rsp (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_capture   (dbg_gnt & ~i_dbg_wren),
    .i_ld_data   (i_lsu_ld_data),
    .o_rsp_valid (o_dbg_rsp_valid),
    .o_ld_data   (o_dbg_ld_data)
  );

  assign o_core_gnt   = core_gnt;
  assign o_dbg_gnt    = dbg_gnt;
  assign o_dbg_locked = (state_q == S_LOCK);

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: directed scenarios followed by random traffic, all
// checked against a wait-count / mode reference model and a small byte LSU.
module tb_lsu_arbiter;
  import lsu_arb_pkg::*;

  localparam int SM = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req = 0, core_wren = 0, core_sgn = 0;
  logic [31:0] core_addr = 0, core_data = 0;
  logic [3:0]  core_lt = 0;
  logic        dbg_req = 0, dbg_wren = 0, dbg_sgn = 0, dbg_lock = 0;
  logic [31:0] dbg_addr = 0, dbg_data = 0;
  logic [3:0]  dbg_lt = 0;
  logic        core_gnt, dbg_gnt, core_rv, dbg_rv, lsu_wren, lsu_sgn, locked;
  logic [31:0] core_ld, dbg_ld, lsu_addr, lsu_st, lsu_rd;
  logic [3:0]  lsu_lt;

  int tests = 0;
  int failed = 0;

  logic [7:0] mem [0:255];

  // Reference model state: dbg wait count, forced-priority flag, lock flag.
  int          m_wait;
  bit          m_forced, m_locked;
  bit          e_cg, e_dg, e_crv, e_drv;
  logic [31:0] e_cld, e_dld, e_ldval;

  always #5 clk = ~clk;

  lsu_arbiter #(.STARVE_MAX(SM)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_core_req(core_req), .i_core_wren(core_wren), .i_core_addr(core_addr),
    .i_core_st_data(core_data), .i_core_load_type(core_lt), .i_core_load_signed(core_sgn),
    .i_dbg_req(dbg_req), .i_dbg_wren(dbg_wren), .i_dbg_addr(dbg_addr),
    .i_dbg_st_data(dbg_data), .i_dbg_load_type(dbg_lt), .i_dbg_load_signed(dbg_sgn),
    .i_dbg_lock(dbg_lock),
    .o_core_gnt(core_gnt), .o_dbg_gnt(dbg_gnt),
    .o_core_rsp_valid(core_rv), .o_dbg_rsp_valid(dbg_rv),
    .o_core_ld_data(core_ld), .o_dbg_ld_data(dbg_ld),
    .o_lsu_addr(lsu_addr), .o_lsu_st_data(lsu_st), .o_lsu_wren(lsu_wren),
    .o_lsu_load_type(lsu_lt), .o_lsu_load_signed(lsu_sgn),
    .i_lsu_ld_data(lsu_rd), .o_dbg_locked(locked)
  );

  function automatic logic [31:0] lsu_read(input logic [31:0] a, input logic [3:0] lt, input logic s);
    logic [7:0]  i0;
    logic [31:0] w;
    i0 = a[7:0];
    w  = {mem[i0 + 8'd3], mem[i0 + 8'd2], mem[i0 + 8'd1], mem[i0]};
    case (lt)
      LT_BYTE: return s ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
      LT_HALF: return s ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always_comb begin
    lsu_rd = lsu_read(lsu_addr, lsu_lt, lsu_sgn);
  end

  // Little-endian byte LSU; load_type doubles as the store size.
  always @(posedge clk) begin
    if (lsu_wren) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 0 || (k == 1 && lsu_lt != LT_BYTE) || (k > 1 && lsu_lt == LT_WORD))
          mem[lsu_addr[7:0] + 8'(k)] <= lsu_st[8*k +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_forced = 0; m_locked = 0;
    e_crv = 0; e_drv = 0; e_cld = '0; e_dld = '0;
  endtask

  // At the falling edge: derive expected grants from the priority rules and
  // compare every DUT output.
  task automatic check_cycle();
    logic [31:0] ea, ed;
    logic [3:0]  elt;
    logic        ew, es;
    @(negedge clk);
    if (m_locked)      begin e_dg = dbg_req; e_cg = 0; end
    else if (m_forced) begin e_dg = dbg_req; e_cg = core_req && !dbg_req; end
    else               begin e_cg = core_req; e_dg = dbg_req && !core_req; end
    ea = 0; ed = 0; elt = 0; ew = 0; es = 0;
    if (e_cg)      begin ea = core_addr; ed = core_data; elt = core_lt; ew = core_wren; es = core_sgn; end
    else if (e_dg) begin ea = dbg_addr;  ed = dbg_data;  elt = dbg_lt;  ew = dbg_wren;  es = dbg_sgn;  end
    e_ldval = lsu_read(ea, elt, es);
    chk("core_gnt", 32'(core_gnt), 32'(e_cg));
    chk("dbg_gnt",  32'(dbg_gnt),  32'(e_dg));
    chk("lsu_addr", lsu_addr, ea);
    chk("lsu_st",   lsu_st,   ed);
    chk("lsu_wren", 32'(lsu_wren), 32'(ew));
    chk("lsu_lt",   32'(lsu_lt),   32'(elt));
    chk("lsu_sgn",  32'(lsu_sgn),  32'(es));
    chk("core_rv",  32'(core_rv),  32'(e_crv));
    chk("dbg_rv",   32'(dbg_rv),   32'(e_drv));
    chk("core_ld",  core_ld, e_cld);
    chk("dbg_ld",   dbg_ld,  e_dld);
    chk("locked",   32'(locked),   32'(m_locked));
  endtask

  task automatic advance();
    bit core_pri;
    @(posedge clk);
    e_crv = e_cg && !core_wren;
    e_drv = e_dg && !dbg_wren;
    if (e_crv) e_cld = e_ldval;
    if (e_drv) e_dld = e_ldval;
    core_pri = !m_locked && !m_forced;
    if (e_dg && dbg_lock)  begin m_locked = 1; m_forced = 0; end
    else if (m_locked)     begin if (!dbg_lock) m_locked = 0; end
    else if (m_forced)     begin if (e_dg || !dbg_req) m_forced = 0; end
    if (e_dg || !dbg_req) m_wait = 0;
    else if (m_wait < SM) m_wait++;
    if (core_pri && !m_locked && m_wait == SM) m_forced = 1;
    #1;
  endtask

  task automatic set_core(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] lt, input logic s);
    core_req = r; core_wren = w; core_addr = a; core_data = d; core_lt = lt; core_sgn = s;
  endtask

  task automatic set_dbg(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] lt, input logic s, input logic lk);
    dbg_req = r; dbg_wren = w; dbg_addr = a; dbg_data = d; dbg_lt = lt; dbg_sgn = s; dbg_lock = lk;
  endtask

  function automatic logic [3:0] rand_lt();
    case ($urandom_range(0, 2))
      0:       return LT_BYTE;
      1:       return LT_HALF;
      default: return LT_WORD;
    endcase
  endfunction

  initial begin
    model_reset();
    // Reset asserted with requests present: everything must be quiet.
    set_core(1, 1, 32'h22, 32'hFFFF_FFFF, LT_WORD, 1);
    set_dbg(1, 1, 32'h44, 32'hFFFF_FFFF, LT_WORD, 1, 1);
    #3;
    chk("rst_core_gnt", 32'(core_gnt), 0);
    chk("rst_dbg_gnt",  32'(dbg_gnt),  0);
    chk("rst_wren",     32'(lsu_wren), 0);
    chk("rst_addr",     lsu_addr, 0);
    chk("rst_locked",   32'(locked), 0);
    set_core(0, 0, 0, 0, 0, 0);
    set_dbg(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Uncontended core store then signed byte load.
    set_core(1, 1, 32'h0000_0022, 32'h1234_5678, LT_HALF, 0);
    check_cycle(); chk("st_core_gnt", 32'(core_gnt), 1); advance();
    set_core(1, 0, 32'h0000_0023, 32'h0, LT_BYTE, 1);
    check_cycle(); chk("ld_core_gnt", 32'(core_gnt), 1); advance();
    set_core(0, 0, 0, 0, 0, 0);
    check_cycle();
    chk("ld_data_56", core_ld, 32'h0000_0056);
    chk("ld_rsp_valid", 32'(core_rv), 1);
    advance();

    // Conflict in core-priority mode.
    set_core(1, 1, 32'h1000_0000, 32'hC0C0_0001, LT_WORD, 0);
    set_dbg(1, 1, 32'h1000_0000, 32'hD0D0_0002, LT_WORD, 0, 0);
    check_cycle();
    chk("conf_core_gnt", 32'(core_gnt), 1);
    chk("conf_dbg_gnt",  32'(dbg_gnt),  0);
    chk("conf_st_data",  lsu_st, 32'hC0C0_0001);
    advance();
    set_core(0, 0, 0, 0, 0, 0);
    check_cycle(); advance();
    set_dbg(0, 0, 0, 0, 0, 0, 0);
    check_cycle(); advance();

    // Starvation: dbg must win on its 9th waiting cycle.
    set_core(1, 1, 32'h1000_0100, 32'h0BAD_F00D, LT_WORD, 0);
    set_dbg(1, 0, 32'h1001_0000, 0, LT_WORD, 0, 0);
    for (int i = 1; i <= SM + 1; i++) begin
      check_cycle();
      if (i <= SM) chk("starve_wait", 32'(dbg_gnt), 0);
      else begin
        chk("starve_dbg_gnt",  32'(dbg_gnt),  1);
        chk("starve_core_gnt", 32'(core_gnt), 0);
      end
      advance();
    end
    set_dbg(1, 0, 32'h1001_0004, 0, LT_WORD, 0, 0);
    check_cycle();
    chk("starve_back_core", 32'(core_gnt), 1);
    chk("starve_back_dbg",  32'(dbg_gnt),  0);
    advance();
    set_core(0, 0, 0, 0, 0, 0);
    check_cycle(); advance();
    set_dbg(0, 0, 0, 0, 0, 0, 0);
    check_cycle(); advance();

    // Locked dbg burst while core keeps requesting.
    set_dbg(1, 1, 32'h1000_2000, 32'hAAAA_AAAA, LT_WORD, 0, 1);
    check_cycle(); chk("lock_first_gnt", 32'(dbg_gnt), 1); advance();
    set_core(1, 0, 32'h0000_0022, 0, LT_HALF, 0);
    set_dbg(1, 1, 32'h1000_3000, 32'h5555_5555, LT_WORD, 0, 1);
    check_cycle();
    chk("lock_core_stall", 32'(core_gnt), 0);
    chk("lock_locked", 32'(locked), 1);
    advance();
    set_dbg(0, 0, 0, 0, 0, 0, 1);
    check_cycle(); chk("lock_hold_core", 32'(core_gnt), 0); advance();
    dbg_lock = 0;
    check_cycle(); chk("lock_drop_core", 32'(core_gnt), 0); advance();
    check_cycle();
    chk("unlock_core_gnt", 32'(core_gnt), 1);
    chk("unlock_locked", 32'(locked), 0);
    advance();
    set_core(0, 0, 0, 0, 0, 0);

    // Reset mid dbg store with a core rsp_valid pending.
    set_core(1, 0, 32'h0000_0022, 0, LT_WORD, 0);
    check_cycle(); advance();
    set_core(0, 0, 0, 0, 0, 0);
    set_dbg(1, 1, 32'h1000_4000, 32'h7777_7777, LT_WORD, 0, 0);
    check_cycle();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_wren", 32'(lsu_wren), 0);
    chk("rst_mid_gnt",  32'(dbg_gnt), 0);
    chk("rst_mid_addr", lsu_addr, 0);
    chk("rst_mid_rv",   32'(core_rv), 0);
    chk("rst_mid_ld",   core_ld, 0);
    set_dbg(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_core(1, 1, 32'h1000_0008, 32'h1111_2222, LT_WORD, 0);
    set_dbg(1, 1, 32'h1000_000C, 32'h3333_4444, LT_WORD, 0, 0);
    check_cycle(); chk("post_rst_core_pri", 32'(core_gnt), 1); advance();
    set_core(0, 0, 0, 0, 0, 0);
    check_cycle(); advance();
    set_dbg(0, 0, 0, 0, 0, 0, 0);

    // Idle.
    for (int i = 0; i < 3; i++) begin
      check_cycle();
      chk("idle_wren", 32'(lsu_wren), 0);
      chk("idle_addr", lsu_addr, 0);
      chk("idle_rv", 32'(core_rv | dbg_rv), 0);
      advance();
    end

    // Random traffic; requests stay stable until the model grants them.
    for (int n = 0; n < 400; n++) begin
      check_cycle();
      advance();
      if (!core_req || e_cg) begin
        if ($urandom_range(0, 9) < 7)
          set_core(1, 1'($urandom), 32'($urandom), 32'($urandom), rand_lt(), 1'($urandom));
        else
          core_req = 0;
      end
      if (!dbg_req || e_dg) begin
        if ($urandom_range(0, 9) < 5)
          set_dbg(1, 1'($urandom), 32'($urandom), 32'($urandom), rand_lt(), 1'($urandom), dbg_lock);
        else
          dbg_req = 0;
      end
      if (dbg_lock) begin
        if ($urandom_range(0, 5) == 0) dbg_lock = 0;
      end else if ($urandom_range(0, 9) == 0) dbg_lock = 1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
